// File: rtl/multitone_stim_gen.sv
// Multi-tone stimulus source: wrapping CORDIC phase accumulators out, masked and
// averaged sine samples in, decimated onto a valid/ready stream for the FIR input.
module multitone_stim_gen #(
  parameter int NUM_TONES = 2,
  parameter int PHASE_W   = 16,
  parameter int DATA_W    = 16,
  parameter int DECIM     = 5,
  parameter int PI_POS    = 25736
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [NUM_TONES*PHASE_W-1:0]   phase_inc,
  input  logic [NUM_TONES-1:0]           tone_mask,
  output logic                           phase_tvalid,
  output logic [NUM_TONES*PHASE_W-1:0]   phase_tdata,
  input  logic                           sin_tvalid,
  input  logic [NUM_TONES*DATA_W-1:0]    sin_tdata,
  output logic                           sample_tvalid,
  input  logic                           sample_tready,
  output logic signed [DATA_W-1:0]       sample_tdata,
  output logic                           drop_sticky
);

  localparam int SH    = $clog2(NUM_TONES);
  localparam int SUM_W = DATA_W + SH;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [PHASE_W+1:0] PI_E     = (PHASE_W+2)'(PI_POS);
  localparam logic signed [PHASE_W+1:0] TWO_PI_E = (PHASE_W+2)'(2 * PI_POS);
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(DECIM - 1);

  // Saturate the increment at +PI, add with two guard bits, fold back into [-PI, +PI].
  function automatic logic signed [PHASE_W-1:0] wrap_add(
    input logic signed [PHASE_W-1:0] p,
    input logic        [PHASE_W-1:0] inc
  );
    logic signed [PHASE_W+1:0] inc_e;
    logic signed [PHASE_W+1:0] s;
    inc_e = $signed({2'b00, inc});
    if (inc_e > PI_E) begin
      inc_e = PI_E;
    end
    s = {{2{p[PHASE_W-1]}}, p} + inc_e;
    if (s > PI_E) begin
      s = s - TWO_PI_E;
    end
    return s[PHASE_W-1:0];
  endfunction

  // Average by arithmetic shift (floor), then drop the growth bits.
  function automatic logic signed [DATA_W-1:0] scale_mix(
    input logic signed [SUM_W-1:0] sum
  );
    logic signed [SUM_W-1:0] sh;
    sh = sum >>> SH;
    return sh[DATA_W-1:0];
  endfunction

  logic [NUM_TONES*PHASE_W-1:0] phase_q, phase_d;
  logic                         phase_vld_q;

  always_comb begin
    phase_d = phase_q;
    if (enable) begin
      for (int k = 0; k < NUM_TONES; k++) begin
        phase_d[k*PHASE_W +: PHASE_W] = wrap_add($signed(phase_q[k*PHASE_W +: PHASE_W]),
                                                 phase_inc[k*PHASE_W +: PHASE_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      phase_vld_q <= enable;
    end
  end

  assign phase_tvalid = phase_vld_q;
  assign phase_tdata  = phase_q;

  // ---- mix stage 1: masked sum of the returned sine samples ----
  logic signed [SUM_W-1:0] sum_d, sum_p1_q;
  logic                    vld_p1_q;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NUM_TONES; k++) begin
      if (tone_mask[k]) begin
        sum_d = sum_d + SUM_W'($signed(sin_tdata[k*DATA_W +: DATA_W]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= sin_tvalid;
      if (sin_tvalid) begin
        sum_p1_q <= sum_d;
      end
    end
  end

  // ---- mix stage 2: scale, decimate, output register ----
  logic signed [DATA_W-1:0] mix_p2;
  logic                     capture_p2;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_vld_q, out_vld_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     drop_q, drop_d;

  always_comb begin
    mix_p2     = scale_mix(sum_p1_q);
    capture_p2 = vld_p1_q && (cnt_q == CNT_LAST);
    cnt_d      = cnt_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    drop_d     = drop_q;
    if (vld_p1_q) begin
      cnt_d = capture_p2 ? '0 : cnt_q + 1'b1;
    end
    if (capture_p2) begin
      if (!out_vld_q || sample_tready) begin
        out_vld_d  = 1'b1;
        out_data_d = mix_p2;
      end else begin
        drop_d = 1'b1;
      end
    end else if (out_vld_q && sample_tready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      drop_q     <= drop_d;
    end
  end

  assign sample_tvalid = out_vld_q;
  assign sample_tdata  = out_data_q;
  assign drop_sticky   = drop_q;

endmodule

// File: tb/tb_multitone_stim_gen.sv
// Bench for multitone_stim_gen: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an arithmetic reference model.
module tb_multitone_stim_gen;

  localparam int NT  = 2;
  localparam int PW  = 16;
  localparam int DW  = 16;
  localparam int DEC = 5;
  localparam int PI  = 25736;
  localparam int DIV = 2;  // averaging divisor for two tones

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [NT*PW-1:0]     phase_inc;
  logic [NT-1:0]        tone_mask;
  logic                 phase_tvalid;
  logic [NT*PW-1:0]     phase_tdata;
  logic                 sin_tvalid;
  logic [NT*DW-1:0]     sin_tdata;
  logic                 sample_tvalid;
  logic                 sample_tready;
  logic signed [DW-1:0] sample_tdata;
  logic                 drop_sticky;

  multitone_stim_gen #(
    .NUM_TONES(NT), .PHASE_W(PW), .DATA_W(DW), .DECIM(DEC), .PI_POS(PI)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .phase_inc(phase_inc), .tone_mask(tone_mask),
    .phase_tvalid(phase_tvalid), .phase_tdata(phase_tdata), .sin_tvalid(sin_tvalid),
    .sin_tdata(sin_tdata), .sample_tvalid(sample_tvalid), .sample_tready(sample_tready),
    .sample_tdata(sample_tdata), .drop_sticky(drop_sticky)
  );

  always #5 clk = ~clk;

  // stimulus variables
  int inc_v[NT];
  int sin_v[NT];

  // reference model state
  int m_ph[NT];
  bit m_pv;
  bit m_beat_v;
  int m_beat_sum;
  int m_beats;
  bit m_sv;
  int m_sd;
  bit m_drop;

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_step();
    bit cap;
    int val, inc, s;
    if (rst) begin
      foreach (m_ph[k]) m_ph[k] = 0;
      m_pv = 0; m_beat_v = 0; m_beat_sum = 0; m_beats = 0;
      m_sv = 0; m_sd = 0; m_drop = 0;
      return;
    end
    if (enable) begin
      for (int k = 0; k < NT; k++) begin
        inc = (inc_v[k] > PI) ? PI : inc_v[k];
        s = m_ph[k] + inc;
        if (s > PI) s = s - 2 * PI;
        m_ph[k] = s;
      end
    end
    m_pv = enable;
    // the beat registered last edge reaches the decimator now; every DEC-th is kept
    cap = 0;
    val = floor_div(m_beat_sum, DIV);
    if (m_beat_v) begin
      m_beats++;
      if (m_beats % DEC == 0) cap = 1;
    end
    if (cap) begin
      if (!m_sv || sample_tready) begin
        m_sv = 1; m_sd = val;
      end else begin
        m_drop = 1;
      end
    end else if (m_sv && sample_tready) begin
      m_sv = 0;
    end
    m_beat_v = sin_tvalid;
    if (sin_tvalid) begin
      m_beat_sum = 0;
      for (int k = 0; k < NT; k++) if (tone_mask[k]) m_beat_sum += sin_v[k];
    end
  endtask

  task automatic compare();
    logic signed [PW-1:0] p;
    chk("phase_tvalid", int'(phase_tvalid), int'(m_pv));
    for (int k = 0; k < NT; k++) begin
      p = phase_tdata[k*PW +: PW];
      chk($sformatf("phase%0d", k), int'(p), m_ph[k]);
    end
    chk("sample_tvalid", int'(sample_tvalid), int'(m_sv));
    chk("sample_tdata", int'(sample_tdata), m_sd);
    chk("drop_sticky", int'(drop_sticky), int'(m_drop));
  endtask

  // apply current stimulus variables, clock one edge, update model, compare
  task automatic tick();
    for (int k = 0; k < NT; k++) begin
      phase_inc[k*PW +: PW] = inc_v[k][PW-1:0];
      sin_tdata[k*DW +: DW] = sin_v[k][DW-1:0];
    end
    if (sample_tvalid && sample_tready) xfer_q.push_back(int'(sample_tdata));
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  function automatic int ph0();
    logic signed [PW-1:0] p;
    p = phase_tdata[PW-1:0];
    return int'(p);
  endfunction

  initial begin
    rst = 1; enable = 0; tone_mask = '1; sin_tvalid = 0; sample_tready = 1;
    phase_inc = '0; sin_tdata = '0;
    foreach (inc_v[k]) inc_v[k] = 0;
    foreach (sin_v[k]) sin_v[k] = 0;
    @(negedge clk);
    do_reset();
    chk("reset_phase0", ph0(), 0);
    chk("reset_pvalid", int'(phase_tvalid), 0);

    // wrap past +PI and equality at +PI
    enable = 1; inc_v[0] = 25600; tick();
    inc_v[0] = 200; tick();
    chk("wrap_lit", ph0(), -25672);
    do_reset();
    inc_v[0] = 25536; tick();
    inc_v[0] = 200; tick();
    chk("eq_pi_lit", ph0(), 25736);

    // increment saturation, then freeze
    do_reset();
    inc_v[0] = 30000; tick();
    chk("sat1_lit", ph0(), 25736);
    tick();
    chk("sat2_lit", ph0(), 0);
    tick();
    enable = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("freeze_lit", ph0(), 25736);
      chk("freeze_pv_lit", int'(phase_tvalid), 0);
    end
    inc_v[0] = 0;

    // mix and mask
    do_reset();
    tone_mask = 2'b11; sin_v[0] = 1000; sin_v[1] = -3001; sample_tready = 1;
    sin_tvalid = 1;
    for (int i = 0; i < DEC; i++) tick();
    sin_tvalid = 0; tick();
    chk("mix_lit", int'(sample_tdata), -1001);
    tone_mask = 2'b01; sin_tvalid = 1;
    for (int i = 0; i < DEC; i++) tick();
    sin_tvalid = 0; tick();
    chk("mask_lit", int'(sample_tdata), 500);

    // decimation, ready held high
    do_reset();
    tone_mask = 2'b11; sin_v[1] = 0; xfer_q.delete();
    begin
      int vcnt;
      vcnt = 0;
      for (int k = 1; k <= 10; k++) begin
        sin_v[0] = k; sin_tvalid = 1; tick();
        if (sample_tvalid) vcnt++;
      end
      sin_tvalid = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (sample_tvalid) vcnt++;
      end
      chk("decim_vcycles_lit", vcnt, 2);
    end
    chk("decim_count_lit", xfer_q.size(), 2);
    if (xfer_q.size() == 2) begin
      chk("decim_s0_lit", xfer_q[0], 2);
      chk("decim_s1_lit", xfer_q[1], 5);
    end

    // backpressure
    do_reset();
    sample_tready = 0; xfer_q.delete();
    for (int k = 1; k <= 10; k++) begin
      sin_v[0] = k; sin_tvalid = 1; tick();
    end
    sin_tvalid = 0; tick(); tick();
    chk("bp_hold_lit", int'(sample_tdata), 2);
    chk("bp_valid_lit", int'(sample_tvalid), 1);
    chk("bp_drop_lit", int'(drop_sticky), 1);
    sample_tready = 1; tick();
    chk("bp_xfer_lit", xfer_q.size(), 1);
    chk("bp_vdrop_lit", int'(sample_tvalid), 0);
    chk("bp_sticky_lit", int'(drop_sticky), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NT; k++) begin
        if ($urandom_range(0, 15) == 0) inc_v[k] = int'($urandom_range(0, 65535));
        else if ($urandom_range(0, 7) == 0) inc_v[k] = int'($urandom_range(0, 4000));
      end
      tone_mask = NT'($urandom_range(0, (1 << NT) - 1));
      sin_tvalid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NT; k++) sin_v[k] = int'($urandom_range(0, 65535)) - 32768;
      sample_tready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 0;

    // reset mid-stream with a held sample and nonzero phases
    enable = 1; inc_v[0] = 1234; inc_v[1] = 777; tone_mask = 2'b11;
    sin_v[0] = 300; sin_v[1] = 100; sample_tready = 0; sin_tvalid = 1;
    for (int i = 0; i < DEC + 1; i++) tick();
    chk("pre_rst_valid_lit", int'(sample_tvalid), 1);
    rst = 1; tick(); rst = 0;
    chk("rst_phase_lit", int'(phase_tdata), 0);
    chk("rst_valid_lit", int'(sample_tvalid), 0);
    chk("rst_data_lit", int'(sample_tdata), 0);
    chk("rst_drop_lit", int'(drop_sticky), 0);
    sample_tready = 1;
    for (int i = 0; i < DEC; i++) begin
      tick();
      chk("rst_nocap_lit", int'(sample_tvalid), 0);
    end
    sin_tvalid = 0; tick();
    chk("rst_cap5_lit", int'(sample_tvalid), 1);
    chk("rst_cap5_data_lit", int'(sample_tdata), 200);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multitone_stim_gen.md
Name: multitone_stim_gen

Overview:
Synthesisable multi-tone stimulus source for FIR filter benches and on-board self-test. It sweeps NUM_TONES independent phase accumulators in CORDIC radian format, wrapping each one at ±PI, and drives them to external CORDIC sin/cos cores. It takes the returned sine samples, masks and averages them, decimates to the FIR sample rate, and presents the result on a valid/ready stream for the FIR input.

Parameters:
NUM_TONES, 2, number of tones and phase channels (1..8)
PHASE_W, 16, phase word width, signed fixed-point CORDIC radians
DATA_W, 16, sine sample and output width, signed
DECIM, 5, accepted sine beats per output sample (CORDIC rate / FIR rate), ≥1
PI_POS, 25736 (16'h6488), +PI in phase format; -PI is taken as -PI_POS

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous reset, active-high
enable  in  1  run phase sweep; low freezes all accumulators
phase_inc  in  NUM_TONES*PHASE_W  per-tone increment, tone k at bits [k*PHASE_W +: PHASE_W], unsigned
tone_mask  in  NUM_TONES  1 = tone included in the mix
phase_tvalid  out  1  phase word valid, to CORDIC
phase_tdata  out  NUM_TONES*PHASE_W  current phases, packed like phase_inc
sin_tvalid  in  1  CORDIC outputs valid, all tones aligned
sin_tdata  in  NUM_TONES*DATA_W  sine samples, packed, signed
sample_tvalid  out  1  mixed sample valid
sample_tready  in  1  FIR side accepts the sample
sample_tdata  out  DATA_W  mixed, decimated sample, signed
drop_sticky  out  1  a decimated sample was lost to backpressure; cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge): all phases=0, phase_tvalid=0, mix pipeline cleared, decimation counter=0, sample_tvalid=0, sample_tdata=0, drop_sticky=0. Reset mid-operation discards any held or in-flight sample.
- Phase sweep, on every clk edge with enable=1:
  - inc_k = min(phase_inc_k, PI_POS), so any increment above PI_POS saturates.
  - s = p_k + inc_k, computed in PHASE_W+2 bits.
  - If s <= PI_POS, p_k <= s. Otherwise p_k <= s - 2*PI_POS.
  - The result always lies in [-PI_POS, PI_POS], and +PI_POS itself is legal.
- phase_tvalid is a register: 1 on the cycle after any edge with enable=1, 0 after any edge with enable=0. phase_tdata always shows the registered phases. While enable=0, the phases hold.
- Mix stage 1: on a sin_tvalid beat, register sum = Σ (tone_mask[k] ? sin_k : 0). The sum is sign-extended to DATA_W+clog2(NUM_TONES) bits, so it cannot overflow. The valid flag is registered alongside it.
- Mix stage 2: mix = sum >>> clog2(NUM_TONES), an arithmetic shift (rounds toward -inf), truncated to DATA_W.
- Decimation counter:
  - Counts stage-1 valid beats from 0 to DECIM-1, wrapping back to 0.
  - When a valid beat arrives with count==DECIM-1, the result is a capture event. With DECIM=1, every beat is a capture.
  - Latency: a capture's sample_tvalid rises 2 clk edges after the corresponding sin_tvalid beat.
- Output register, sample_tvalid/sample_tdata:
  - Capture while empty, or while valid with sample_tready=1 (transfer and load in the same cycle): load mix, sample_tvalid=1.
  - Capture while valid with sample_tready=0: keep the old sample, discard the new one, set drop_sticky=1.
  - No capture, valid, sample_tready=1: sample_tvalid <= 0.
  - sample_tdata is stable while sample_tvalid=1 and sample_tready=0.
- Changes to tone_mask and phase_inc take effect at the next clk edge. No restart is needed.

Test Plan:
1. Wrap: PHASE_W=16, tone0 p=25600, inc=200, enable=1 -> next phase -25672. From p=25536, inc=200 -> next phase 25736 (no wrap at equality).
2. Saturation and freeze: inc=30000 from p=0 -> phases 25736, then 0 (25736+25736-51472). enable=0 for 4 cycles -> phase holds and phase_tvalid=0 from the next cycle.
3. Mix and mask: NUM_TONES=2, sin0=1000, sin1=-3001, DECIM=1, both tones enabled -> sample_tdata=-1001 two cycles after the beat. Set tone_mask=2'b01 -> 500.
4. Decimation: DECIM=5, 10 consecutive sin_tvalid beats with sin0=k (k=1..10), sin1=0, sample_tready=1 -> two samples only, values 2 (5>>>1) and 5 (10>>>1), each valid 1 cycle.
5. Backpressure: as scenario 4 but sample_tready=0 throughout -> sample_tdata=2 held, second capture dropped, drop_sticky=1. Then raise sample_tready -> one transfer, sample_tvalid drops, drop_sticky stays 1.
6. Reset mid-stream: rst=1 for one edge while sample_tvalid=1 and the phases are nonzero -> next cycle all outputs 0. The counter restarts, so the next output appears on the 5th subsequent beat.
